sample_collector: RTL and testbench

Round-robin scheduler for the shared sample-readback bus of the pin-controller array. It polls each enabled channel in turn by asserting `output_sample` and `channel_select`, then captures the 32-bit word returned on `sample_data`. A word is pushed into an internal first-word-fall-through (FWFT) FIFO only when the channel's sample count has advanced. The block sits between the pin-controller array and the host-side readout logic and is the only driver of `output_sample` and `channel_select`.

---
 rtl/sample_collector.sv | 166 ++++++++++++++++
 tb/tb_sample_collector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sample_collector.sv
// Round-robin poller for the shared sample-readback bus. Captures each polled
// channel's word and queues it in a FWFT FIFO when its sample count advances.
module sample_collector #(
  parameter int NUM_CHANNELS = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NUM_CHANNELS-1:0]       channel_mask,
  output logic                          output_sample,
  output logic [7:0]                    channel_select,
  input  logic [31:0]                   sample_data,
  input  logic                          fifo_rd,
  output logic [31:0]                   fifo_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [15:0]                   error_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [14:0] MARKER = {12'hABC, 3'b111};

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  ptr_reg, ptr_next;
  logic [IW-1:0] ptr_idx;
  logic [7:0]  lowest_idx, next_idx;
  logic        mask_any;
  logic        clear_seen;
  logic        output_sample_reg;

  logic [31:0] cap_reg;
  logic [14:0] cap_cnt;
  logic        cap_valid;
  logic        unused_cap_msb;

  logic [NUM_CHANNELS-1:0] seen_reg;
  logic [14:0] last_cnt_reg [NUM_CHANNELS];

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic        push_req, push, drop, pop;
  logic        overflow_reg;
  logic [15:0] error_count_reg;

  assign mask_any = |channel_mask;
  assign ptr_idx  = ptr_reg[IW-1:0];

  // Descending scans: the last hit is the smallest qualifying index.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (channel_mask[i]) lowest_idx = 8'(i);
    end
    next_idx = lowest_idx;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (channel_mask[i] && (8'(i) > ptr_reg)) next_idx = 8'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    clear_seen = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (enable && mask_any) begin
          state_next = REQ;
          ptr_next   = lowest_idx;
          clear_seen = 1'b1;
        end
      end
      REQ:  state_next = WAIT;
      WAIT: state_next = CAPT;
      CAPT: begin
        if (mask_any) ptr_next = next_idx;
        state_next = (enable && mask_any) ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      ptr_reg           <= '0;
      output_sample_reg <= 1'b0;
      cap_reg           <= '0;
    end else begin
      state_reg         <= state_next;
      ptr_reg           <= ptr_next;
      output_sample_reg <= (state_next == REQ);
      if (state_reg == WAIT) cap_reg <= sample_data;
    end
  end

  assign output_sample  = output_sample_reg;
  assign channel_select = ptr_reg;

  assign cap_cnt        = cap_reg[30:16];
  assign cap_valid      = (cap_reg[15:1] == MARKER);
  assign unused_cap_msb = cap_reg[31];

  assign push_req = (state_reg == CAPT) && cap_valid &&
                    (!seen_reg[ptr_idx] || (cap_cnt != last_cnt_reg[ptr_idx]));
  // Full is judged on the pre-pop state, so a simultaneous pop cannot make room.
  assign push     = push_req && !fifo_full;
  assign drop     = push_req && fifo_full;
  assign pop      = fifo_rd && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seen_reg <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) last_cnt_reg[i] <= '0;
    end else if (clear_seen) begin
      seen_reg <= '0;
    end else if (push) begin
      seen_reg[ptr_idx]     <= 1'b1;
      last_cnt_reg[ptr_idx] <= cap_cnt;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + CW'(1);
    else if (pop && !push) count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {ptr_reg, 8'h00, cap_cnt, cap_reg[0]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      error_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      if (drop)              overflow_reg <= 1'b1;
      else if (overflow_clr) overflow_reg <= 1'b0;
      if ((state_reg == CAPT) && !cap_valid && (error_count_reg != 16'hFFFF))
        error_count_reg <= error_count_reg + 16'd1;
    end
  end

  assign fifo_empty  = (count_reg == '0);
  assign fifo_full   = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_count  = count_reg;
  assign fifo_data   = fifo_empty ? 32'h0 : mem[rd_ptr_reg];
  assign overflow    = overflow_reg;
  assign error_count = error_count_reg;

endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector: a behavioural pin-controller array answers
// polls from a per-channel word table; expected FIFO entries are hand-computed.
module tb_sample_collector;

  localparam int NCH   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            fifo_rd = 1'b0;
  logic            overflow_clr = 1'b0;
  logic [NCH-1:0]  channel_mask = '0;
  logic            output_sample;
  logic [7:0]      channel_select;
  logic [31:0]     sample_data = '0;
  logic [31:0]     fifo_data;
  logic            fifo_empty, fifo_full, overflow;
  logic [2:0]      fifo_count;
  logic [15:0]     error_count;
  logic [31:0]     chan_word [NCH];

  int checks = 0;
  int errors = 0;

  sample_collector #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .channel_mask(channel_mask),
    .output_sample(output_sample), .channel_select(channel_select),
    .sample_data(sample_data), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .overflow(overflow), .overflow_clr(overflow_clr), .error_count(error_count)
  );

  // Selected pin controller registers its word at the end of the strobe cycle.
  always @(posedge clk) begin
    if (output_sample) sample_data <= chan_word[channel_select[3:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check_eq(tag, fifo_data, exp);
    fifo_rd = 1'b1;
    run(1);
    fifo_rd = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) chan_word[i] = 32'h0;

    // Reset state
    run(3);
    check_eq("rst_os",    32'(output_sample), 32'h0);
    check_eq("rst_cs",    32'(channel_select), 32'h0);
    check_eq("rst_data",  fifo_data, 32'h0);
    check_eq("rst_empty", 32'(fifo_empty), 32'h1);
    check_eq("rst_full",  32'(fifo_full), 32'h0);
    check_eq("rst_count", 32'(fifo_count), 32'h0);
    check_eq("rst_ovf",   32'(overflow), 32'h0);
    check_eq("rst_err",   32'(error_count), 32'h0);
    reset_n = 1'b1;
    run(1);

    // Mask 0x0005: ch0 cnt=1 pin=1, ch2 cnt=7 pin=1; cadence and push latency
    chan_word[0] = 32'h0001ABCF;
    chan_word[2] = 32'h0007ABCF;
    channel_mask = 16'h0005;
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      run(1);
      check_eq($sformatf("cad_os_k%0d", k), 32'(output_sample), (k % 3 == 0) ? 32'h1 : 32'h0);
      if (k % 3 == 0)
        check_eq($sformatf("cad_cs_k%0d", k), 32'(channel_select), ((k / 3) % 2 == 0) ? 32'h0 : 32'h2);
      if (k == 2) check_eq("lat_empty_k2", 32'(fifo_empty), 32'h1);
      if (k == 3) begin
        check_eq("lat_empty_k3", 32'(fifo_empty), 32'h0);
        check_eq("lat_data_k3", fifo_data, 32'h00000003);
      end
    end
    run(12);
    check_eq("norepeat_count", 32'(fifo_count), 32'h2);
    pop_check("pop_ch0", 32'h00000003);
    pop_check("pop_ch2", 32'h0200000F);
    check_eq("drained_empty", 32'(fifo_empty), 32'h1);

    // Add ch1 (cnt 3), then advance it to cnt 4
    chan_word[1] = 32'h0003ABCE;
    channel_mask = 16'h0007;
    run(15);
    check_eq("ch1_new_count", 32'(fifo_count), 32'h1);
    pop_check("ch1_cnt3", 32'h01000006);
    chan_word[1] = 32'h0004ABCE;
    run(15);
    check_eq("ch1_adv_count", 32'(fifo_count), 32'h1);
    pop_check("ch1_cnt4", 32'h01000008);

    // Invalid words on ch3: exactly five polls
    enable = 1'b0;
    run(6);
    check_eq("idle_os", 32'(output_sample), 32'h0);
    channel_mask = 16'h0008;
    chan_word[3] = 32'h0;
    enable = 1'b1;
    run(15);
    enable = 1'b0;
    run(5);
    check_eq("err_count5", 32'(error_count), 32'd5);
    check_eq("err_nopush", 32'(fifo_count), 32'h0);

    // Overflow with six distinct words into a 4-deep FIFO
    chan_word[3] = 32'h0002ABCE;
    chan_word[4] = 32'h0005ABCF;
    chan_word[5] = 32'h0009ABCE;
    channel_mask = 16'h003F;
    enable = 1'b1;
    run(19);
    check_eq("ovf_count", 32'(fifo_count), 32'h4);
    check_eq("ovf_full",  32'(fifo_full), 32'h1);
    check_eq("ovf_flag",  32'(overflow), 32'h1);
    check_eq("ovf_head",  fifo_data, 32'h00000003);
    fifo_rd = 1'b1;
    run(1);
    fifo_rd = 1'b0;
    check_eq("ovf_pop_count", 32'(fifo_count), 32'h3);
    check_eq("ovf_pop_head",  fifo_data, 32'h01000008);
    check_eq("ovf_pop_full",  32'(fifo_full), 32'h0);
    run(15);
    check_eq("retry_count", 32'(fifo_count), 32'h4);
    check_eq("retry_full",  32'(fifo_full), 32'h1);
    enable = 1'b0;
    run(4);
    check_eq("ovf_still_set", 32'(overflow), 32'h1);
    overflow_clr = 1'b1;
    run(1);
    overflow_clr = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'h0);
    pop_check("ovf_e1", 32'h01000008);
    pop_check("ovf_e2", 32'h0200000F);
    pop_check("ovf_e3", 32'h03000004);
    pop_check("ovf_e4", 32'h0400000B);
    check_eq("ovf_drained_data", fifo_data, 32'h0);

    // Enable dropped during WAIT: the in-flight push still lands
    channel_mask = 16'h0001;
    enable = 1'b1;
    run(1);
    check_eq("drop_req_os", 32'(output_sample), 32'h1);
    run(1);
    enable = 1'b0;
    run(2);
    check_eq("drop_os_k3",    32'(output_sample), 32'h0);
    check_eq("drop_count_k3", 32'(fifo_count), 32'h1);
    run(2);
    check_eq("drop_os_k5", 32'(output_sample), 32'h0);
    pop_check("drop_entry", 32'h00000003);

    // Re-enable pushes seen words again; then reset mid-REQ with 3 entries
    channel_mask = 16'h0007;
    enable = 1'b1;
    run(4);
    check_eq("reen_head",  fifo_data, 32'h00000003);
    check_eq("reen_count", 32'(fifo_count), 32'h1);
    run(6);
    check_eq("pre_rst_count", 32'(fifo_count), 32'h3);
    check_eq("pre_rst_os",    32'(output_sample), 32'h1);
    reset_n = 1'b0;
    run(1);
    check_eq("mid_rst_os",    32'(output_sample), 32'h0);
    check_eq("mid_rst_cs",    32'(channel_select), 32'h0);
    check_eq("mid_rst_data",  fifo_data, 32'h0);
    check_eq("mid_rst_empty", 32'(fifo_empty), 32'h1);
    check_eq("mid_rst_count", 32'(fifo_count), 32'h0);
    check_eq("mid_rst_err",   32'(error_count), 32'h0);
    reset_n = 1'b1;
    enable = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
